// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: E->M register, req/ack data-memory
// handshake with byte lanes and load extraction, and the M->W writeback register.
module mem_stage #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_e_i,
    input  logic               reg_write_e_i,
    input  logic [1:0]         result_src_e_i,
    input  logic               mem_write_e_i,
    input  logic [2:0]         funct3_e_i,
    input  logic [D_WIDTH-1:0] alu_result_e_i,
    input  logic [D_WIDTH-1:0] write_data_e_i,
    input  logic [4:0]         rd_e_i,
    input  logic [D_WIDTH-1:0] pc_plus_4e_i,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [D_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]         dmem_be_o,
    output logic [D_WIDTH-1:0] dmem_wdata_o,
    input  logic               dmem_ack_i,
    input  logic [D_WIDTH-1:0] dmem_rdata_i,
    output logic               stall_m_o,
    output logic               misalign_o,
    output logic               valid_w_o,
    output logic               reg_write_w_o,
    output logic [1:0]         result_src_w_o,
    output logic [4:0]         rd_w_o,
    output logic [D_WIDTH-1:0] alu_result_w_o,
    output logic [D_WIDTH-1:0] read_data_w_o,
    output logic [D_WIDTH-1:0] pc_plus_4w_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             r_state;
    logic               r_valid_m;
    logic               r_reg_write_m;
    logic [1:0]         r_result_src_m;
    logic               r_mem_write_m;
    logic [2:0]         r_funct3_m;
    logic [D_WIDTH-1:0] r_alu_m;
    logic [D_WIDTH-1:0] r_wd_m;
    logic [4:0]         r_rd_m;
    logic [D_WIDTH-1:0] r_pc4_m;

    logic               w_is_load;
    logic               w_mem_op;
    logic               w_legal;
    logic               w_aligned;
    logic               w_ok;
    logic               w_req;
    logic               w_stall;
    logic               w_retire;
    logic               w_misalign;
    logic [1:0]         w_off;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [D_WIDTH-1:0] w_load_data;
    logic [3:0]         w_be;
    logic [D_WIDTH-1:0] w_wdata;

    // A store flag wins over result_src if both are set.
    assign w_is_load = (r_result_src_m == 2'b01) && !r_mem_write_m;
    assign w_mem_op  = r_valid_m && (r_mem_write_m || (r_result_src_m == 2'b01));
    assign w_off     = r_alu_m[1:0];

    always_comb begin
        w_legal = 1'b0;
        if (r_mem_write_m)
            w_legal = (r_funct3_m == 3'b000) || (r_funct3_m == 3'b001) || (r_funct3_m == 3'b010);
        else
            w_legal = (r_funct3_m == 3'b000) || (r_funct3_m == 3'b001) || (r_funct3_m == 3'b010)
                   || (r_funct3_m == 3'b100) || (r_funct3_m == 3'b101);
    end

    always_comb begin
        w_aligned = 1'b0;
        case (r_funct3_m[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = !w_off[0];
            2'b10:   w_aligned = (w_off == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_ok       = w_mem_op && w_legal && w_aligned;
    // M is frozen while waiting, so the request stays asserted from either state.
    assign w_req      = (r_state == S_WAIT) || w_ok;
    assign w_stall    = w_req && !dmem_ack_i;
    assign w_retire   = !w_stall;
    assign w_misalign = (r_state == S_IDLE) && w_mem_op && !w_ok;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = '0;
        if (r_mem_write_m) begin
            case (r_funct3_m[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{r_wd_m[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << w_off;
                    w_wdata = {2{r_wd_m[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = r_wd_m;
                end
            endcase
        end
    end

    assign w_byte = dmem_rdata_i[{w_off, 3'b000} +: 8];
    assign w_half = dmem_rdata_i[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = '0;
        case (r_funct3_m)
            3'b000:  w_load_data = {{(D_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(D_WIDTH-16){w_half[15]}}, w_half};
            3'b010:  w_load_data = dmem_rdata_i;
            3'b100:  w_load_data = {{(D_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(D_WIDTH-16){1'b0}}, w_half};
            default: w_load_data = '0;
        endcase
    end

    assign dmem_req_o   = w_req;
    assign dmem_we_o    = r_mem_write_m;
    assign dmem_addr_o  = {r_alu_m[D_WIDTH-1:2], 2'b00};
    assign dmem_be_o    = w_be;
    assign dmem_wdata_o = w_wdata;
    assign stall_m_o    = w_stall;
    assign misalign_o   = w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_m      <= 1'b0;
            r_reg_write_m  <= 1'b0;
            r_result_src_m <= 2'b00;
            r_mem_write_m  <= 1'b0;
            r_funct3_m     <= 3'b000;
            r_alu_m        <= '0;
            r_wd_m         <= '0;
            r_rd_m         <= 5'd0;
            r_pc4_m        <= '0;
        end else if (!w_stall) begin
            r_valid_m      <= valid_e_i;
            r_reg_write_m  <= reg_write_e_i;
            r_result_src_m <= result_src_e_i;
            r_mem_write_m  <= mem_write_e_i;
            r_funct3_m     <= funct3_e_i;
            r_alu_m        <= alu_result_e_i;
            r_wd_m         <= write_data_e_i;
            r_rd_m         <= rd_e_i;
            r_pc4_m        <= pc_plus_4e_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else if (w_req && dmem_ack_i)
            r_state <= S_IDLE;
        else if (w_req)
            r_state <= S_WAIT;
    end

    // A non-retiring M slot hands W a bubble so no instruction is written back twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_w_o      <= 1'b0;
            reg_write_w_o  <= 1'b0;
            result_src_w_o <= 2'b00;
            rd_w_o         <= 5'd0;
            alu_result_w_o <= '0;
            read_data_w_o  <= '0;
            pc_plus_4w_o   <= '0;
        end else if (w_retire) begin
            valid_w_o      <= r_valid_m;
            reg_write_w_o  <= r_valid_m && r_reg_write_m && !w_misalign;
            result_src_w_o <= r_result_src_m;
            rd_w_o         <= r_rd_m;
            alu_result_w_o <= r_alu_m;
            read_data_w_o  <= (w_req && w_is_load) ? w_load_data : '0;
            pc_plus_4w_o   <= r_pc4_m;
        end else begin
            valid_w_o      <= 1'b0;
            reg_write_w_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected memory requests
// and writeback bundles; monitors pop and compare as the DUT presents them.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_e_i = 1'b0, reg_write_e_i = 1'b0, mem_write_e_i = 1'b0;
    logic [1:0]  result_src_e_i = 2'b00;
    logic [2:0]  funct3_e_i = 3'b000;
    logic [31:0] alu_result_e_i = '0, write_data_e_i = '0, pc_plus_4e_i = '0;
    logic [4:0]  rd_e_i = 5'd0;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i, stall_m_o, misalign_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_be_o;
    logic        valid_w_o, reg_write_w_o;
    logic [1:0]  result_src_w_o;
    logic [4:0]  rd_w_o;
    logic [31:0] alu_result_w_o, read_data_w_o, pc_plus_4w_o;

    int          n_vec = 0, n_err = 0;
    int          ack_delay = 0, wait_cnt = 0;
    logic [31:0] rdata_v = '0;
    int          stall_cnt = 0, mis_cnt = 0;
    logic        in_wait = 1'b0;

    typedef struct {logic rw; logic [1:0] rs; logic [4:0] rd; logic [31:0] alu;
                    logic chk_rd; logic [31:0] rdata;} wexp_t;
    typedef struct {logic we; logic [31:0] addr; logic [3:0] be;
                    logic chk_wd; logic [31:0] wdata;} rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];

    mem_stage #(.D_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_e_i(valid_e_i), .reg_write_e_i(reg_write_e_i),
        .result_src_e_i(result_src_e_i), .mem_write_e_i(mem_write_e_i),
        .funct3_e_i(funct3_e_i), .alu_result_e_i(alu_result_e_i),
        .write_data_e_i(write_data_e_i), .rd_e_i(rd_e_i), .pc_plus_4e_i(pc_plus_4e_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .stall_m_o(stall_m_o), .misalign_o(misalign_o),
        .valid_w_o(valid_w_o), .reg_write_w_o(reg_write_w_o),
        .result_src_w_o(result_src_w_o), .rd_w_o(rd_w_o),
        .alu_result_w_o(alu_result_w_o), .read_data_w_o(read_data_w_o),
        .pc_plus_4w_o(pc_plus_4w_o)
    );

    always #5 clk = ~clk;

    // Memory responder: ack once the request has waited ack_delay cycles.
    assign dmem_ack_i   = dmem_req_o && (wait_cnt == ack_delay);
    assign dmem_rdata_i = rdata_v;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (dmem_req_o && !dmem_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Request and writeback monitors.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_wait = 1'b0;
        end else begin
            if (stall_m_o) stall_cnt++;
            if (misalign_o) mis_cnt++;
            if (dmem_req_o && !in_wait) begin
                if (rq.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    rexp_t r;
                    r = rq.pop_front();
                    chk("req_we", {31'd0, dmem_we_o}, {31'd0, r.we});
                    chk("req_addr", dmem_addr_o, r.addr);
                    chk("req_be", {28'd0, dmem_be_o}, {28'd0, r.be});
                    if (r.chk_wd) chk("req_wdata", dmem_wdata_o, r.wdata);
                end
            end
            in_wait = dmem_req_o && !dmem_ack_i;
            if (valid_w_o) begin
                if (wq.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    chk("w_reg_write", {31'd0, reg_write_w_o}, {31'd0, w.rw});
                    chk("w_result_src", {30'd0, result_src_w_o}, {30'd0, w.rs});
                    chk("w_rd", {27'd0, rd_w_o}, {27'd0, w.rd});
                    chk("w_alu_result", alu_result_w_o, w.alu);
                    if (w.chk_rd) chk("w_read_data", read_data_w_o, w.rdata);
                end
            end
        end
    end

    // Present one instruction in E and hold it until the E->M register takes it.
    task automatic issue(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd);
        int guard;
        valid_e_i = 1'b1; reg_write_e_i = rw; result_src_e_i = rs; mem_write_e_i = mw;
        funct3_e_i = f3; alu_result_e_i = alu; write_data_e_i = wd; rd_e_i = rd;
        pc_plus_4e_i = alu + 32'h1000;
        guard = 0;
        while (stall_m_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("issue_timeout", 32'd1, 32'd0);
        @(negedge clk);
        valid_e_i = 1'b0; reg_write_e_i = 1'b0; mem_write_e_i = 1'b0; result_src_e_i = 2'b00;
    endtask

    task automatic push_w(input logic rw, input logic [1:0] rs, input logic [4:0] rd,
                          input logic [31:0] alu, input logic chk_rd, input logic [31:0] rdata);
        wexp_t w;
        w.rw = rw; w.rs = rs; w.rd = rd; w.alu = alu; w.chk_rd = chk_rd; w.rdata = rdata;
        wq.push_back(w);
    endtask

    task automatic push_r(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic chk_wd, input logic [31:0] wdata);
        rexp_t r;
        r.we = we; r.addr = addr; r.be = be; r.chk_wd = chk_wd; r.wdata = wdata;
        rq.push_back(r);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((wq.size() != 0 || rq.size() != 0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("drain_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s0, m0;
        #12;
        chk("rst_valid_w", {31'd0, valid_w_o}, 32'd0);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_m_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // SW 0x12345678 to 0x100, zero-wait; W shows it two edges after capture
        ack_delay = 0; s0 = stall_cnt;
        push_r(1'b1, 32'h100, 4'b1111, 1'b1, 32'h12345678);
        push_w(1'b0, 2'b00, 5'd0, 32'h100, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 3'b010, 32'h100, 32'h12345678, 5'd0);
        @(negedge clk);
        chk("sw_latency_valid_w", {31'd0, valid_w_o}, 32'd1);
        drain();
        chk("sw_stall_cycles", stall_cnt - s0, 32'd0);

        // LB 0x103 with three stalled cycles before ack
        ack_delay = 3; rdata_v = 32'h80000000; s0 = stall_cnt;
        push_r(1'b0, 32'h100, 4'b0000, 1'b0, 32'h0);
        push_w(1'b1, 2'b01, 5'd5, 32'h103, 1'b1, 32'hFFFFFF80);
        issue(1'b1, 2'b01, 1'b0, 3'b000, 32'h103, 32'h0, 5'd5);
        drain();
        chk("lb_stall_cycles", stall_cnt - s0, 32'd3);

        // LHU 0x102 zero-wait
        ack_delay = 0; rdata_v = 32'hBEEF1234;
        push_r(1'b0, 32'h100, 4'b0000, 1'b0, 32'h0);
        push_w(1'b1, 2'b01, 5'd6, 32'h102, 1'b1, 32'h0000BEEF);
        issue(1'b1, 2'b01, 1'b0, 3'b101, 32'h102, 32'h0, 5'd6);
        drain();

        // SB 0xAB to 0x102, then SH 0x1234ABCD to 0x102
        push_r(1'b1, 32'h100, 4'b0100, 1'b1, 32'hABABABAB);
        push_w(1'b0, 2'b00, 5'd0, 32'h102, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 3'b000, 32'h102, 32'h000000AB, 5'd0);
        push_r(1'b1, 32'h100, 4'b1100, 1'b1, 32'hABCDABCD);
        push_w(1'b0, 2'b00, 5'd0, 32'h102, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0);
        drain();

        // Byte/half sign edges and a one-wait LW
        rdata_v = 32'h007F0000;
        push_r(1'b0, 32'h100, 4'b0000, 1'b0, 32'h0);
        push_w(1'b1, 2'b01, 5'd10, 32'h102, 1'b1, 32'h0000007F);
        issue(1'b1, 2'b01, 1'b0, 3'b000, 32'h102, 32'h0, 5'd10);
        drain();
        rdata_v = 32'h80010000;
        push_r(1'b0, 32'h100, 4'b0000, 1'b0, 32'h0);
        push_w(1'b1, 2'b01, 5'd11, 32'h102, 1'b1, 32'hFFFF8001);
        issue(1'b1, 2'b01, 1'b0, 3'b001, 32'h102, 32'h0, 5'd11);
        drain();
        ack_delay = 1; rdata_v = 32'hCAFEF00D;
        push_r(1'b0, 32'h104, 4'b0000, 1'b0, 32'h0);
        push_w(1'b1, 2'b01, 5'd12, 32'h104, 1'b1, 32'hCAFEF00D);
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h104, 32'h0, 5'd12);
        drain();
        ack_delay = 0;

        // Plain ALU op: no request, writes rd
        push_w(1'b1, 2'b00, 5'd9, 32'h0000DEAD, 1'b0, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 3'b000, 32'h0000DEAD, 32'h0, 5'd9);
        drain();

        // SH to 0x101, LW from 0x102, illegal load funct3 011: squashed, one pulse each
        m0 = mis_cnt;
        push_w(1'b0, 2'b00, 5'd0, 32'h101, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 3'b001, 32'h101, 32'h5555, 5'd0);
        push_w(1'b0, 2'b01, 5'd7, 32'h102, 1'b0, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h102, 32'h0, 5'd7);
        push_w(1'b0, 2'b01, 5'd8, 32'h100, 1'b0, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 3'b011, 32'h100, 32'h0, 5'd8);
        drain();
        chk("misalign_pulses", mis_cnt - m0, 32'd3);

        // Reset during WAIT drops the pending access without a clock
        ack_delay = 20;
        push_r(1'b0, 32'h200, 4'b0000, 1'b0, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'h0, 5'd13);
        repeat (2) @(negedge clk);
        chk("wait_stall_before_rst", {31'd0, stall_m_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_async_stall", {31'd0, stall_m_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid_w", {31'd0, valid_w_o}, 32'd0);
        end
        push_w(1'b1, 2'b10, 5'd14, 32'h300, 1'b0, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 3'b000, 32'h300, 32'h0, 5'd14);
        drain();

        chk("wq_empty", wq.size(), 32'd0);
        chk("rq_empty", rq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
